mul_arbiter: RTL and testbench
==============================

# mul_arbiter

Round-robin arbiter that shares one sequential `Multiplier` instance (LEN-bit operands, 2·LEN-bit product, start/finish handshake) among NREQ requesters. Each requester uses a valid/ready request channel and a valid/ready response channel. The block sequences the multiplier: it latches one request, pulses `mul_start`, waits for `mul_finish`, and returns the product to the granted requester. It sits between the core's functional units and the single multiplier datapath.

## Interface
- `NREQ`, 4: number of requesters (2..8).
- `LEN`, 32: operand width; product is 2·LEN.
- `clk`  in  1  clock, rising edge.
- `rstn`  in  1  asynchronous, active-low reset.
- `req_valid`  in  NREQ  per-requester request valid.
- `req_ready`  out  NREQ  per-requester accept; at most one bit set.
- `req_a`  in  NREQ·LEN  packed multiplicands; slice i belongs to requester i.
- `req_b`  in  NREQ·LEN  packed multipliers.
- `rsp_valid`  out  NREQ  per-requester response valid; at most one bit set.
- `rsp_ready`  in  NREQ  per-requester response accept.
- `rsp_product`  out  2·LEN  product for the requester whose `rsp_valid` is set.
- `mul_start`  out  1  one-cycle start pulse to the multiplier.
- `mul_multiplicand`, `mul_multiplier`  out  LEN each  operands to the multiplier.
- `mul_product`  in  2·LEN  multiplier result.
- `mul_finish`  in  1  multiplier done; product valid in that cycle.
- `busy`  out  1  high in every state except IDLE.
- `spurious_finish`  out  1  sticky; set when `mul_finish` arrives outside WAIT.

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: the picker chooses g = the first i with `req_valid[i]`, searching from `last+1` mod NREQ upward. `req_ready[g]` is combinational, so it is high in the same cycle. On acceptance, latch g, `req_a[g]`, and `req_b[g]`, then go to ISSUE. If no request is valid, all `req_ready` bits are 0.
- ISSUE: `mul_start`=1 for exactly this cycle, then go to WAIT.
- WAIT: `mul_start`=0. On `mul_finish`, register `mul_product` into `rsp_product` and go to RESP.
- RESP: `rsp_valid[g]`=1 and `rsp_product` is held stable. When `rsp_ready[g]` is high, set `last`=g and go to IDLE.
- `mul_multiplicand`/`mul_multiplier` drive the latched operands continuously from ISSUE through WAIT. They keep their last values in other states and are never changed mid-operation.
- `req_ready` is 0 in ISSUE, WAIT and RESP. Requests that are not granted stay pending; the arbiter does not drop them.
- `mul_finish` in IDLE, ISSUE or RESP: ignored for data and sets `spurious_finish`. Only reset clears the flag.
- Fairness: a requester holding `req_valid` high waits at most NREQ−1 other operations before it is granted.

## Timing
- Reset (rstn=0, asynchronous):
  - state=IDLE and `last`=NREQ−1, so requester 0 has first priority.
  - All outputs are 0: `req_ready`, `rsp_valid`, `rsp_product`, `mul_start`, operands, `busy`, `spurious_finish`.
- Reset mid-operation aborts the transaction: no response is produced. The multiplier is reset from the same `rstn`.
- If a request is accepted at edge T and the multiplier asserts finish K cycles after start:
  - `mul_start` is high in cycle T+1.
  - `mul_finish` arrives in cycle T+1+K.
  - `rsp_valid` is high from cycle T+2+K.
- The earliest next acceptance is the cycle after the `rsp_ready` handshake.
- Throughput: one operation per K+3 cycles, with zero response backpressure.
- A simultaneous `mul_finish` and a new `req_valid` in WAIT has no interaction: the request waits until IDLE.
- `rsp_ready` on a non-granted index is ignored.

## Structure
- Package `mul_arb_pkg`:
  - state enum `arb_state_t` (IDLE/ISSUE/WAIT/RESP);
  - default `LEN`/`NREQ` localparams;
  - `idx_t` width $clog2(NREQ).
- Sub-module `rr_picker`: a combinational round-robin select. Inputs are a `req` vector and `last` index; outputs are `grant_onehot`, `grant_idx` and `any`.
- Top level holds the FSM, operand/product registers and the `last` pointer. Estimated size is about 200 RTL lines.

## Test plan
- Single request: requester 2 with a=20, b=40.
  - Expect one `mul_start` pulse with operands 20/40.
  - Expect `rsp_valid`=4'b0100 and `rsp_product`=800.
  - Expect `req_ready[2]` high for exactly one cycle.
- All four requesters valid from reset, with a=i+1 and b=10:
  - grant order is 0,1,2,3;
  - products are 10,20,30,40;
  - then repeat requester 0 gives 10.
- Response backpressure: hold `rsp_ready`=0 for 5 cycles.
  - `rsp_product` stays stable and `rsp_valid` stays high.
  - No new `mul_start` is issued and `busy`=1 throughout.
- Edge operands: a=32'hFFFFFFFF, b=32'hFFFFFFFF gives 64'hFFFFFFFE00000001; a=0 gives 0.
- Reset mid-operation:
  - drop `rstn` during WAIT → all outputs are 0 immediately;
  - a new request after reset is granted starting from requester 0.
- Inject `mul_finish` in IDLE → `spurious_finish`=1 stays set, and no `rsp_valid` is produced.

Source files
------------

// File: rtl/mul_arbiter_pkg.sv
// Shared types and defaults for the multiplier arbiter.
package mul_arb_pkg;

  localparam int DEF_NREQ = 4;
  localparam int DEF_LEN  = 32;
  localparam int IDX_W    = $clog2(DEF_NREQ);

  typedef logic [IDX_W-1:0] idx_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_t;

endpackage

// File: rtl/mul_arbiter_if.sv
// Request/response channels plus the shared multiplier port, bundled for the arbiter.
interface mul_arbiter_if #(
  parameter int NREQ = 4,
  parameter int LEN  = 32
);
  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ*LEN-1:0] req_a;
  logic [NREQ*LEN-1:0] req_b;
  logic [NREQ-1:0]     rsp_valid;
  logic [NREQ-1:0]     rsp_ready;
  logic [2*LEN-1:0]    rsp_product;
  logic                mul_start;
  logic [LEN-1:0]      mul_multiplicand;
  logic [LEN-1:0]      mul_multiplier;
  logic [2*LEN-1:0]    mul_product;
  logic                mul_finish;
  logic                busy;
  logic                spurious_finish;

  modport master (
    output req_valid, req_a, req_b, rsp_ready, mul_product, mul_finish,
    input  req_ready, rsp_valid, rsp_product, mul_start, mul_multiplicand,
           mul_multiplier, busy, spurious_finish
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready, mul_product, mul_finish,
    output req_ready, rsp_valid, rsp_product, mul_start, mul_multiplicand,
           mul_multiplier, busy, spurious_finish
  );
endinterface

// File: rtl/mul_arbiter_rr_picker.sv
// Combinational round-robin select: first asserted request after the last grant.
module rr_picker #(
  parameter int NREQ = 4,
  parameter int IW   = 2
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IW-1:0]   i_last,
  output logic [NREQ-1:0] o_grant_onehot,
  output logic [IW-1:0]   o_grant_idx,
  output logic            o_any
);

  int w_pos;

  // Walk the ring starting just past the previous winner; the first hit wins.
  always_comb begin
    o_grant_onehot = '0;
    o_grant_idx    = '0;
    o_any          = 1'b0;
    w_pos          = 0;
    for (int k = 0; k < NREQ; k++) begin
      w_pos = (int'(i_last) + 1 + k) % NREQ;
      if (!o_any && i_req[w_pos[IW-1:0]]) begin
        o_grant_onehot[w_pos[IW-1:0]] = 1'b1;
        o_grant_idx                   = w_pos[IW-1:0];
        o_any                         = 1'b1;
      end else begin
        o_any = o_any;
      end
    end
  end

endmodule

// File: rtl/mul_arbiter.sv
// Round-robin arbiter sequencing one shared multiplier among NREQ requesters.
module mul_arbiter
  import mul_arb_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int LEN  = DEF_LEN
) (
  input logic          i_clk,
  input logic          i_rstn,
  mul_arbiter_if.slave bus
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  arb_state_t       r_state;
  logic [IW-1:0]    r_last;
  logic [IW-1:0]    r_gidx;
  logic [NREQ-1:0]  r_gsel;
  logic [NREQ-1:0]  r_rsp_valid;
  logic [LEN-1:0]   r_opa;
  logic [LEN-1:0]   r_opb;
  logic [2*LEN-1:0] r_prod;
  logic             r_start;
  logic             r_busy;
  logic             r_spur;

  logic [NREQ-1:0]  w_onehot;
  logic [IW-1:0]    w_gidx;
  logic             w_any;
  logic             w_idle;
  logic [LEN-1:0]   w_a;
  logic [LEN-1:0]   w_b;

  rr_picker #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_picker (
    .i_req          (bus.req_valid),
    .i_last         (r_last),
    .o_grant_onehot (w_onehot),
    .o_grant_idx    (w_gidx),
    .o_any          (w_any)
  );

  // One-hot operand mux for the current pick.
  always_comb begin
    w_a = '0;
    w_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_a = w_a | (bus.req_a[i*LEN +: LEN] & {LEN{w_onehot[i]}});
      w_b = w_b | (bus.req_b[i*LEN +: LEN] & {LEN{w_onehot[i]}});
    end
  end

  // Accept is combinational; gated by reset so every output reads 0 while rstn is low.
  assign w_idle               = (r_state == ST_IDLE) && i_rstn;
  assign bus.req_ready        = w_idle ? w_onehot : {NREQ{1'b0}};
  assign bus.rsp_valid        = r_rsp_valid;
  assign bus.rsp_product      = r_prod;
  assign bus.mul_start        = r_start;
  assign bus.mul_multiplicand = r_opa;
  assign bus.mul_multiplier   = r_opb;
  assign bus.busy             = r_busy;
  assign bus.spurious_finish  = r_spur;

  // Arbiter FSM with its operand, product and pointer registers.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_state     <= ST_IDLE;
      r_last      <= IW'(NREQ - 1);
      r_gidx      <= '0;
      r_gsel      <= '0;
      r_rsp_valid <= '0;
      r_opa       <= '0;
      r_opb       <= '0;
      r_prod      <= '0;
      r_start     <= 1'b0;
      r_busy      <= 1'b0;
      r_spur      <= 1'b0;
    end else begin
      if (bus.mul_finish && (r_state != ST_WAIT)) begin
        r_spur <= 1'b1;
      end
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_gidx  <= w_gidx;
            r_gsel  <= w_onehot;
            r_opa   <= w_a;
            r_opb   <= w_b;
            r_start <= 1'b1;
            r_busy  <= 1'b1;
            r_state <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          r_start <= 1'b0;
          r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (bus.mul_finish) begin
            r_prod      <= bus.mul_product;
            r_rsp_valid <= r_gsel;
            r_state     <= ST_RESP;
          end
        end
        ST_RESP: begin
          // Only the granted requester's ready completes the handshake.
          if (|(bus.rsp_ready & r_gsel)) begin
            r_rsp_valid <= '0;
            r_last      <= r_gidx;
            r_busy      <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_start     <= 1'b0;
          r_rsp_valid <= '0;
          r_busy      <= 1'b0;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_arbiter.sv
// Self-checking bench: directed plan items plus randomized traffic against a round-robin model.
module tb_mul_arbiter;

  localparam int NR = 4;
  localparam int W  = 32;

  logic clk;
  logic rstn;
  int   total;
  int   bad;

  mul_arbiter_if #(.NREQ(NR), .LEN(W)) bus ();

  mul_arbiter #(.NREQ(NR), .LEN(W)) dut (
    .i_clk  (clk),
    .i_rstn (rstn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in sequential multiplier: finish arrives mul_k cycles after the start pulse.
  int          mul_k;
  int          m_cnt;
  logic [W-1:0] m_a;
  logic [W-1:0] m_b;
  logic        spur_inj;
  int          start_cnt;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_cnt <= 0;
      m_a   <= '0;
      m_b   <= '0;
    end else if (bus.mul_start) begin
      m_cnt <= mul_k;
      m_a   <= bus.mul_multiplicand;
      m_b   <= bus.mul_multiplier;
    end else if (m_cnt != 0) begin
      m_cnt <= m_cnt - 1;
    end
  end

  always @(posedge clk or negedge rstn) begin
    if (!rstn) start_cnt <= 0;
    else if (bus.mul_start) start_cnt <= start_cnt + 1;
  end

  assign bus.mul_product = {32'd0, m_a} * {32'd0, m_b};
  assign bus.mul_finish  = (m_cnt == 1) || spur_inj;

  // Reference state: what each requester wants and who won last.
  logic [NR-1:0] pend_v;
  logic [W-1:0]  pend_a [NR];
  logic [W-1:0]  pend_b [NR];
  int            ref_last;
  int            ops;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick_ref();
    int i;
    for (int k = 1; k <= NR; k++) begin
      i = (ref_last + k) % NR;
      if (pend_v[i]) return i;
    end
    return -1;
  endfunction

  task automatic apply_reqs();
    for (int i = 0; i < NR; i++) begin
      bus.req_valid[i]       = pend_v[i];
      bus.req_a[i*W +: W]    = pend_a[i];
      bus.req_b[i*W +: W]    = pend_b[i];
    end
  endtask

  task automatic check_zero(input string pfx);
    chk({pfx, "_req_ready"}, 64'(bus.req_ready), 64'd0);
    chk({pfx, "_rsp_valid"}, 64'(bus.rsp_valid), 64'd0);
    chk({pfx, "_rsp_product"}, bus.rsp_product, 64'd0);
    chk({pfx, "_mul_start"}, 64'(bus.mul_start), 64'd0);
    chk({pfx, "_mcand"}, 64'(bus.mul_multiplicand), 64'd0);
    chk({pfx, "_mplier"}, 64'(bus.mul_multiplier), 64'd0);
    chk({pfx, "_busy"}, 64'(bus.busy), 64'd0);
    chk({pfx, "_spurious"}, 64'(bus.spurious_finish), 64'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    rstn     = 1'b1;
    ref_last = NR - 1;
    ops      = 0;
  endtask

  // One full operation; called at a negedge with the DUT idle.
  task automatic do_txn(input int k, input int bp, output int g);
    logic [NR-1:0] oh;
    logic [63:0]   exp_p;
    int            n;
    g = pick_ref();
    if (g < 0) g = 0;
    oh    = '0;
    oh[g] = 1'b1;
    exp_p = {32'd0, pend_a[g]} * {32'd0, pend_b[g]};
    mul_k = k;
    apply_reqs();
    #1;
    chk("req_ready_grant", 64'(bus.req_ready), 64'(oh));
    @(negedge clk);
    chk("mul_start_pulse", 64'(bus.mul_start), 64'd1);
    chk("mcand", 64'(bus.mul_multiplicand), 64'(pend_a[g]));
    chk("mplier", 64'(bus.mul_multiplier), 64'(pend_b[g]));
    chk("req_ready_issue", 64'(bus.req_ready), 64'd0);
    chk("busy_issue", 64'(bus.busy), 64'd1);
    pend_v[g] = 1'b0;
    apply_reqs();
    n = 0;
    while (bus.rsp_valid == '0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("latency", 64'(n), 64'(k + 1));
    chk("rsp_valid", 64'(bus.rsp_valid), 64'(oh));
    chk("rsp_product", bus.rsp_product, exp_p);
    chk("mcand_hold", 64'(bus.mul_multiplicand), 64'(pend_a[g]));
    for (int c = 0; c < bp; c++) begin
      bus.rsp_ready = ~oh;
      @(negedge clk);
      chk("bp_rsp_valid", 64'(bus.rsp_valid), 64'(oh));
      chk("bp_product", bus.rsp_product, exp_p);
      chk("bp_busy", 64'(bus.busy), 64'd1);
    end
    bus.rsp_ready = oh;
    @(negedge clk);
    bus.rsp_ready = '0;
    chk("rsp_drop", 64'(bus.rsp_valid), 64'd0);
    chk("busy_idle", 64'(bus.busy), 64'd0);
    ref_last = g;
    ops++;
    chk("start_count", 64'(start_cnt), 64'(ops));
  endtask

  initial begin
    int g;
    total         = 0;
    bad           = 0;
    rstn          = 1'b0;
    spur_inj      = 1'b0;
    mul_k         = 1;
    ops           = 0;
    ref_last      = NR - 1;
    pend_v        = '0;
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = '0;
    for (int i = 0; i < NR; i++) begin
      pend_a[i] = '0;
      pend_b[i] = '0;
    end

    repeat (2) @(negedge clk);
    check_zero("reset");
    rstn = 1'b1;

    // Single request from requester 2.
    pend_v[2] = 1'b1; pend_a[2] = 32'd20; pend_b[2] = 32'd40;
    do_txn(3, 0, g);
    chk("single_grant", 64'(g), 64'd2);

    // All four from reset: strict rotation 0..3, then requester 0 again.
    do_reset();
    for (int i = 0; i < NR; i++) begin
      pend_v[i] = 1'b1; pend_a[i] = 32'(i + 1); pend_b[i] = 32'd10;
    end
    for (int i = 0; i < NR; i++) begin
      do_txn(2, 0, g);
      chk("rr_order", 64'(g), 64'(i));
    end
    pend_v[0] = 1'b1;
    do_txn(1, 0, g);
    chk("rr_repeat0", 64'(g), 64'd0);

    // Backpressure plus edge operands.
    pend_v[1] = 1'b1; pend_a[1] = 32'd7; pend_b[1] = 32'd9;
    do_txn(4, 5, g);
    pend_v[3] = 1'b1; pend_a[3] = 32'hFFFF_FFFF; pend_b[3] = 32'hFFFF_FFFF;
    do_txn(2, 1, g);
    chk("edge_grant", 64'(g), 64'd3);
    pend_v[0] = 1'b1; pend_a[0] = 32'd0; pend_b[0] = 32'hDEAD_BEEF;
    do_txn(1, 0, g);

    // Randomized traffic; pending requests persist until granted.
    for (int it = 0; it < 30; it++) begin
      for (int i = 0; i < NR; i++) begin
        if (!pend_v[i] && ($urandom_range(0, 1) == 1)) begin
          pend_v[i] = 1'b1; pend_a[i] = $urandom; pend_b[i] = $urandom;
        end
      end
      if (pend_v == '0) begin
        pend_v[it % NR] = 1'b1; pend_a[it % NR] = $urandom; pend_b[it % NR] = $urandom;
      end
      do_txn(int'($urandom_range(1, 6)), int'($urandom_range(0, 3)), g);
    end

    // Reset while the multiplier is busy.
    pend_v = '1;
    mul_k  = 8;
    apply_reqs();
    repeat (4) @(negedge clk);
    rstn = 1'b0;
    #1;
    check_zero("midreset");
    repeat (2) @(negedge clk);
    rstn     = 1'b1;
    ref_last = NR - 1;
    ops      = 0;
    for (int i = 0; i < NR; i++) begin
      pend_a[i] = 32'(i + 3); pend_b[i] = 32'd5;
    end
    do_txn(3, 0, g);
    chk("post_reset_grant", 64'(g), 64'd0);

    // Spurious finish while idle.
    pend_v = '0;
    apply_reqs();
    chk("spur_clear", 64'(bus.spurious_finish), 64'd0);
    spur_inj = 1'b1;
    @(negedge clk);
    spur_inj = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("spur_flag", 64'(bus.spurious_finish), 64'd1);
      chk("spur_no_rsp", 64'(bus.rsp_valid), 64'd0);
      chk("spur_idle", 64'(bus.busy), 64'd0);
    end
    pend_v[2] = 1'b1; pend_a[2] = 32'd11; pend_b[2] = 32'd13;
    do_txn(2, 0, g);
    chk("spur_sticky", 64'(bus.spurious_finish), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
